axis_packet_arbiter: RTL and testbench

//  Round-robin packet arbiter. Shares one AXIS egress (e.g. eth_framer payload input or rmii_to_axis TX)

---
 rtl/axis_packet_arbiter.sv | 145 ++++++++++++++
 tb/tb_axis_packet_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_packet_arbiter.sv
// axis_packet_arbiter
//   Round-robin packet arbiter that shares one AXI-Stream egress between
//   NUM_STREAMS packet sources. A grant is held from the first beat to the
//   tlast beat, so packets never interleave. An optional idle gap of
//   GAP_CYCLES cycles is enforced after every packet.
//
// Ports
//   clk            clock
//   sresetn        synchronous reset, active low
//   axis_i_tready  per-stream ready (bit i = stream i)
//   axis_i_tvalid  per-stream valid
//   axis_i_tlast   per-stream last
//   axis_i_tdata   stream i at [i*8*AXIS_BYTES +: 8*AXIS_BYTES]
//   axis_o_tready  egress ready
//   axis_o_tvalid  egress valid
//   axis_o_tlast   egress last
//   axis_o_tdata   egress data
//   grant_idx      currently / most recently granted stream
module axis_packet_arbiter #(
  parameter int NUM_STREAMS = 2,
  parameter int AXIS_BYTES  = 1,
  parameter int GAP_CYCLES  = 0
) (
  input  logic                                              clk,
  input  logic                                              sresetn,
  output logic [NUM_STREAMS-1:0]                            axis_i_tready,
  input  logic [NUM_STREAMS-1:0]                            axis_i_tvalid,
  input  logic [NUM_STREAMS-1:0]                            axis_i_tlast,
  input  logic [NUM_STREAMS*8*AXIS_BYTES-1:0]               axis_i_tdata,
  input  logic                                              axis_o_tready,
  output logic                                              axis_o_tvalid,
  output logic                                              axis_o_tlast,
  output logic [8*AXIS_BYTES-1:0]                           axis_o_tdata,
  output logic [((NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1)-1:0] grant_idx
);

  localparam int DW = 8 * AXIS_BYTES;
  localparam int GW = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;
  localparam int CW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t          r_state;
  logic [GW-1:0]   r_grant;
  logic [CW-1:0]   r_gap_cnt;

  logic            w_any;
  logic [GW-1:0]   w_next;
  logic [GW-1:0]   w_scan_idx;
  logic            w_sel_valid;
  logic            w_sel_last;
  logic [DW-1:0]   w_sel_data;
  logic            w_last_hs;

  // Round-robin pick: scan grant+1, grant+2, ... so the last winner is checked last.
  always_comb begin
    w_any      = 1'b0;
    w_next     = r_grant;
    w_scan_idx = r_grant;
    for (int k = 1; k <= NUM_STREAMS; k++) begin
      w_scan_idx = GW'((int'(r_grant) + k) % NUM_STREAMS);
      if (!w_any && axis_i_tvalid[w_scan_idx]) begin
        w_any  = 1'b1;
        w_next = w_scan_idx;
      end else begin
        w_any  = w_any;
      end
    end
  end

  // Select the granted stream's beat.
  always_comb begin
    w_sel_valid = axis_i_tvalid[r_grant];
    w_sel_last  = axis_i_tlast[r_grant];
    w_sel_data  = axis_i_tdata[int'(r_grant) * DW +: DW];
  end

  // Zero-latency pass-through while a packet is open; everything quiet otherwise.
  // tvalid never depends on egress tready, so no ready->valid loop is created.
  always_comb begin
    axis_o_tvalid = 1'b0;
    axis_o_tlast  = 1'b0;
    axis_o_tdata  = {DW{1'b0}};
    axis_i_tready = {NUM_STREAMS{1'b0}};
    if (r_state == ST_PASS) begin
      axis_o_tvalid          = w_sel_valid;
      axis_o_tlast           = w_sel_last;
      axis_o_tdata           = w_sel_data;
      axis_i_tready[r_grant] = axis_o_tready;
    end else begin
      axis_o_tvalid = 1'b0;
    end
  end

  assign w_last_hs = axis_o_tvalid & axis_o_tready & axis_o_tlast;
  assign grant_idx = r_grant;

  // Arbitration FSM: IDLE picks a winner, PASS holds it to tlast, GAP enforces idle cycles.
  always_ff @(posedge clk) begin
    if (!sresetn) begin
      r_state   <= ST_IDLE;
      r_grant   <= GW'(NUM_STREAMS - 1);
      r_gap_cnt <= {CW{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_grant <= w_next;
            r_state <= ST_PASS;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_PASS: begin
          if (w_last_hs) begin
            if (GAP_CYCLES > 0) begin
              // GAP lasts load+1 cycles, so load one less than the gap length.
              r_gap_cnt <= CW'(GAP_CYCLES - 1);
              r_state   <= ST_GAP;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_state <= ST_PASS;
          end
        end
        ST_GAP: begin
          if (r_gap_cnt == {CW{1'b0}}) begin
            r_state <= ST_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt - {{(CW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// tb_axis_packet_arbiter
//   Directed bench for axis_packet_arbiter (3 streams, 1 byte, 5-cycle gap).
//   Source models replay per-stream packet queues; expected egress beats are
//   pushed in hand-derived order and a negedge monitor pops and compares them.
module tb_axis_packet_arbiter;

  localparam int NS  = 3;
  localparam int GAP = 5;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic [1:0] s;
  } beat_t;

  logic          clk = 1'b0;
  logic          sresetn = 1'b0;
  logic [NS-1:0] axis_i_tready;
  logic [NS-1:0] axis_i_tvalid = '0;
  logic [NS-1:0] axis_i_tlast = '0;
  logic [NS*8-1:0] axis_i_tdata = '0;
  logic          axis_o_tready = 1'b1;
  logic          axis_o_tvalid;
  logic          axis_o_tlast;
  logic [7:0]    axis_o_tdata;
  logic [1:0]    grant_idx;

  logic [8:0]    sq [NS][$];
  beat_t         exp_q [$];
  logic [NS-1:0] stall = '0;
  int            ready_mode = 0;
  int            gap_exact = 0;
  int            n_cmp = 0;
  int            n_err = 0;

  axis_packet_arbiter #(
    .NUM_STREAMS(NS),
    .AXIS_BYTES (1),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk          (clk),
    .sresetn      (sresetn),
    .axis_i_tready(axis_i_tready),
    .axis_i_tvalid(axis_i_tvalid),
    .axis_i_tlast (axis_i_tlast),
    .axis_i_tdata (axis_i_tdata),
    .axis_o_tready(axis_o_tready),
    .axis_o_tvalid(axis_o_tvalid),
    .axis_o_tlast (axis_o_tlast),
    .axis_o_tdata (axis_o_tdata),
    .grant_idx    (grant_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic src_pkt(input int s, input int base, input int len);
    for (int b = 0; b < len; b++)
      sq[s].push_back({(b == len - 1) ? 1'b1 : 1'b0, 8'(base + b)});
  endtask

  task automatic exp_beat(input int s, input int d, input bit l);
    beat_t e;
    e.d = 8'(d);
    e.l = l;
    e.s = 2'(s);
    exp_q.push_back(e);
  endtask

  task automatic exp_pkt(input int s, input int base, input int len);
    for (int b = 0; b < len; b++) exp_beat(s, base + b, b == len - 1);
  endtask

  // Source models: retire handshaken beats, present the next one after each edge.
  initial begin : src_drv
    logic [NS-1:0] hs;
    forever begin
      @(negedge clk);
      hs = axis_i_tvalid & axis_i_tready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NS; i++) begin
        if (hs[i] && sq[i].size() > 0) void'(sq[i].pop_front());
        if (sq[i].size() > 0 && !stall[i]) begin
          axis_i_tvalid[i]       = 1'b1;
          axis_i_tdata[i*8 +: 8] = sq[i][0][7:0];
          axis_i_tlast[i]        = sq[i][0][8];
        end else begin
          axis_i_tvalid[i] = 1'b0;
          axis_i_tlast[i]  = 1'b0;
        end
      end
      case (ready_mode)
        1:       axis_o_tready = 1'($urandom_range(0, 1));
        2:       axis_o_tready = 1'b0;
        default: axis_o_tready = 1'b1;
      endcase
    end
  end

  // Monitor: compare every egress handshake against the scoreboard, check
  // ready routing and the idle gap between packets.
  initial begin : mon
    int after_last;
    int idle;
    beat_t e;
    after_last = 0;
    idle = 0;
    forever begin
      @(negedge clk);
      if (!sresetn) begin
        after_last = 0;
      end else if (axis_o_tvalid) begin
        if (after_last != 0) begin
          if (gap_exact != 0) chk("gap_exact", idle, GAP + 1);
          else                chk("gap_min", int'(idle >= GAP + 1), 1);
          after_last = 0;
        end
        for (int i = 0; i < NS; i++) begin
          if (i == int'(grant_idx)) chk("tready_granted", int'(axis_i_tready[i]), int'(axis_o_tready));
          else                      chk("tready_other", int'(axis_i_tready[i]), 0);
        end
        if (axis_o_tready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", int'(axis_o_tdata), -1);
          end else begin
            e = exp_q.pop_front();
            chk("data", int'(axis_o_tdata), int'(e.d));
            chk("last", int'(axis_o_tlast), int'(e.l));
            chk("grant", int'(grant_idx), int'(e.s));
          end
          if (axis_o_tlast) begin
            after_last = 1;
            idle = 0;
          end
        end
      end else if (after_last != 0) begin
        idle++;
      end
    end
  end

  task automatic do_reset();
    sresetn = 1'b0;
    for (int i = 0; i < NS; i++) sq[i].delete();
    exp_q.delete();
    stall = '0;
    axis_i_tvalid = '0;
    axis_i_tlast = '0;
    ready_mode = 0;
    gap_exact = 0;
    repeat (2) @(posedge clk);
    #2 sresetn = 1'b1;
    @(negedge clk);
    chk("rst_tvalid", int'(axis_o_tvalid), 0);
    chk("rst_grant", int'(grant_idx), NS - 1);
    chk("rst_tready", int'(axis_i_tready), 0);
  endtask

  task automatic wait_drain(input int max_cyc, input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_drain"}, exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_src(input int s, input int sz, input int max_cyc, input string tag);
    int n;
    n = 0;
    while (sq[s].size() != sz && n < max_cyc) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk({tag, "_src_wait"}, sq[s].size(), sz);
  endtask

  // Six packets across three always-busy streams; order must be 0,1,2,0,1,2.
  task automatic load_mix();
    exp_pkt(0, 'h20, 3); exp_pkt(1, 'h30, 4); exp_pkt(2, 'h40, 2);
    exp_pkt(0, 'h50, 2); exp_pkt(1, 'h60, 1); exp_pkt(2, 'h70, 3);
    src_pkt(0, 'h20, 3); src_pkt(0, 'h50, 2);
    src_pkt(1, 'h30, 4); src_pkt(1, 'h60, 1);
    src_pkt(2, 'h40, 2); src_pkt(2, 'h70, 3);
  endtask

  initial begin
    // Basic 4-beat packet from stream 0.
    do_reset();
    exp_pkt(0, 'h10, 4);
    src_pkt(0, 'h10, 4);
    wait_drain(100, "t1");

    // Round robin across three busy streams, back-to-back gaps exact.
    do_reset();
    gap_exact = 1;
    load_mix();
    wait_drain(400, "t2");
    gap_exact = 0;

    // Same traffic with random egress backpressure.
    do_reset();
    ready_mode = 1;
    gap_exact = 1;
    load_mix();
    wait_drain(800, "t4");
    gap_exact = 0;
    ready_mode = 0;

    // Reset in the middle of a stream 1 packet.
    do_reset();
    exp_beat(1, 'hA0, 1'b0);
    exp_beat(1, 'hA1, 1'b0);
    src_pkt(1, 'hA0, 6);
    wait_src(1, 4, 50, "t5");
    ready_mode = 2;
    axis_o_tready = 1'b0;
    sresetn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t5_tvalid_after_rst", int'(axis_o_tvalid), 0);
    chk("t5_grant_after_rst", int'(grant_idx), NS - 1);
    @(posedge clk);
    #2;
    sresetn = 1'b1;
    sq[1].delete();
    axis_i_tvalid[1] = 1'b0;
    ready_mode = 0;
    exp_pkt(0, 'hB0, 2);
    exp_pkt(1, 'hC0, 1);
    src_pkt(0, 'hB0, 2);
    src_pkt(1, 'hC0, 1);
    wait_drain(100, "t5");

    // Granted stream 1 stalls mid-packet while stream 0 waits.
    do_reset();
    exp_pkt(1, 'h80, 4);
    exp_pkt(0, 'h90, 3);
    src_pkt(1, 'h80, 4);
    wait_src(1, 2, 50, "t6");
    stall[1] = 1'b1;
    axis_i_tvalid[1] = 1'b0;
    src_pkt(0, 'h90, 3);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t6_bubble_tvalid", int'(axis_o_tvalid), 0);
      chk("t6_hold_grant", int'(grant_idx), 1);
    end
    @(posedge clk);
    #2 stall[1] = 1'b0;
    wait_drain(100, "t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
